// File: rtl/if_fetch.sv
// Instruction-fetch stage for the 5-stage RV32 pipeline.
// Owns the fetch PC and issues pipelined word fetches to instruction memory.
// In-order responses are buffered in a small FIFO whose head feeds the IF/ID register.
// A redirect flushes the FIFO and discards every fetch still in flight.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect_valid/_pc        EX-stage redirect and its word-aligned target
//   block_if                  downstream stall; holds the FIFO head
//   imem_req/_addr/_gnt       fetch request handshake
//   imem_rvalid/_rdata        in-order fetch responses
//   ins_l0/pc_l0/ins_valid_l0 FIFO head to IF/ID (NOP and PC 0 when empty)
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        block_if,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_l0,
    output logic [31:0] pc_l0,
    output logic        ins_valid_l0
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Control state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_cnt_q,  out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] fifo_wr_q,  fifo_wr_d;
    logic [AW-1:0] fifo_rd_q,  fifo_rd_d;
    logic [AW-1:0] tag_wr_q,   tag_wr_d;
    logic [AW-1:0] tag_rd_q,   tag_rd_d;

    // Storage (data only, no reset needed)
    logic [31:0] fifo_ins_q [DEPTH];
    logic [31:0] fifo_ins_d [DEPTH];
    logic [31:0] fifo_pc_q  [DEPTH];
    logic [31:0] fifo_pc_d  [DEPTH];
    logic [31:0] tag_q      [DEPTH];
    logic [31:0] tag_d      [DEPTH];

    logic credit_ok;
    logic fire;
    logic rsp;
    logic drop_now;
    logic push;
    logic pop;

    // Credit counts both buffered entries and everything in flight, dropped ones included
    always_comb begin
        credit_ok = ((CW+1)'(fifo_cnt_q) + (CW+1)'(out_cnt_q)) < (CW+1)'(DEPTH);
        imem_req  = !rst && !redirect_valid && credit_ok;
        imem_addr = fetch_pc_q;
    end

    // Head of FIFO drives IF/ID; NOP bubble when empty
    always_comb begin
        ins_valid_l0 = (fifo_cnt_q != '0);
        ins_l0       = ins_valid_l0 ? fifo_ins_q[fifo_rd_q] : NOP;
        pc_l0        = ins_valid_l0 ? fifo_pc_q[fifo_rd_q]  : 32'h0;
    end

    // Next-state logic
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        fifo_ins_d = fifo_ins_q;
        fifo_pc_d  = fifo_pc_q;
        tag_d      = tag_q;

        fire     = imem_req && imem_gnt;
        // Responses with nothing outstanding (stragglers across reset) are ignored
        rsp      = imem_rvalid && (out_cnt_q != '0);
        drop_now = (drop_cnt_q != '0);
        push     = rsp && !drop_now && !redirect_valid;
        pop      = ins_valid_l0 && !block_if && !redirect_valid;

        if (fire) begin
            tag_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d        = tag_wr_q + AW'(1);
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end

        if (rsp) begin
            tag_rd_d = tag_rd_q + AW'(1);
            if (drop_now) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end

        out_cnt_d = out_cnt_q + CW'(fire) - CW'(rsp);

        if (push) begin
            fifo_ins_d[fifo_wr_q] = imem_rdata;
            fifo_pc_d[fifo_wr_q]  = tag_q[tag_rd_q];
            fifo_wr_d             = fifo_wr_q + AW'(1);
        end
        if (pop) begin
            fifo_rd_d = fifo_rd_q + AW'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

        // Redirect wins: flush FIFO, everything still in flight becomes droppable
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            fifo_cnt_d = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            drop_cnt_d = out_cnt_d;
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Payload storage
    always_ff @(posedge clk) begin
        fifo_ins_q <= fifo_ins_d;
        fifo_pc_q  <= fifo_pc_d;
        tag_q      <= tag_d;
    end

endmodule
